// File: rtl/spi_frame_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spi_frame_loader
//  Purpose  : Streams 1-bpp frames from SPI flash (READ 0x03, mode 0) into
//             the off-screen video bank, one pixel write per received bit,
//             then waits for a bank swap before fetching the next frame.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_frame_loader #(
    parameter int          X_WIDTH     = 8,
    parameter int          Y_HEIGHT    = 6,
    parameter int          NUM_FRAMES  = 32,
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter bit          LOOP        = 1'b0,
    localparam int         FRAME_BITS  = X_WIDTH * Y_HEIGHT,
    localparam int         FRAME_BYTES = (FRAME_BITS + 7) / 8,
    localparam int         X_ADDRW     = (X_WIDTH    > 1) ? $clog2(X_WIDTH)    : 1,
    localparam int         Y_ADDRW     = (Y_HEIGHT   > 1) ? $clog2(Y_HEIGHT)   : 1,
    localparam int         FI_W        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               CLK_40,
    input  logic               reset,
    input  logic               SPI_clk_en,
    input  logic               start,
    input  logic               bank_swap,
    input  logic               MISO,
    output logic               SPI_CS_n,
    output logic               SPI_SCLK,
    output logic               SPI_MOSI,
    output logic               pixel_data,
    output logic               pixel_we,
    output logic [X_ADDRW-1:0] mem_x_pos,
    output logic [Y_ADDRW-1:0] mem_y_pos,
    output logic               frame_ready,
    output logic [FI_W-1:0]    frame_index,
    output logic               done
);

    localparam logic [7:0] C_CMD_READ = 8'h03;
    localparam int         DATA_BITS  = FRAME_BYTES * 8;
    localparam int         CNT_MAX    = (DATA_BITS > 32) ? DATA_BITS : 32;
    localparam int         CNT_W      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CMD       = 3'd1,
        S_ADDR      = 3'd2,
        S_DATA      = 3'd3,
        S_WAIT_SWAP = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t             state_q;
    logic               cs_n_q;
    logic               sclk_q;
    logic               mosi_q;
    logic [30:0]        tx_q;          // header bits still to be sent after MOSI
    logic [CNT_W-1:0]   cnt_q;         // completed bits in CMD+ADDR, or in DATA
    logic               pix_data_q;
    logic               pix_we_q;
    logic [X_ADDRW-1:0] x_q;
    logic [Y_ADDRW-1:0] y_q;
    logic               frame_ready_q;
    logic [FI_W-1:0]    frame_index_q;
    logic               done_q;

    logic [FI_W:0]      index_inc_d;
    logic               index_wrap_d;
    logic [FI_W-1:0]    index_d;
    logic [23:0]        addr_d;

    // Index and flash address of the frame that follows the one currently held
    always_comb begin
        index_inc_d  = {1'b0, frame_index_q} + (FI_W+1)'(1);
        index_wrap_d = (index_inc_d == (FI_W+1)'(NUM_FRAMES));
        index_d      = index_wrap_d ? '0 : index_inc_d[FI_W-1:0];
        addr_d       = BASE_ADDR + 24'(index_d) * 24'(FRAME_BYTES);
    end

    // Frame-fetch state machine; SPI activity advances only on SPI_clk_en ticks
    always_ff @(posedge CLK_40) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cs_n_q        <= 1'b1;
            sclk_q        <= 1'b0;
            mosi_q        <= 1'b0;
            tx_q          <= '0;
            cnt_q         <= '0;
            pix_data_q    <= 1'b0;
            pix_we_q      <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            frame_ready_q <= 1'b0;
            frame_index_q <= '0;
            done_q        <= 1'b0;
        end else begin
            pix_we_q <= 1'b0;

            // Write address moves on once the strobe for the current pixel is out
            if (pix_we_q) begin
                if (x_q == X_ADDRW'(X_WIDTH - 1)) begin
                    x_q <= '0;
                    y_q <= y_q + Y_ADDRW'(1);
                end else begin
                    x_q <= x_q + X_ADDRW'(1);
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q       <= S_CMD;
                        frame_index_q <= '0;
                        cs_n_q        <= 1'b0;
                        sclk_q        <= 1'b0;
                        mosi_q        <= C_CMD_READ[7];
                        tx_q          <= {C_CMD_READ[6:0], BASE_ADDR};
                        cnt_q         <= '0;
                    end
                end

                S_CMD, S_ADDR, S_DATA: begin
                    if (SPI_clk_en) begin
                        if (!sclk_q) begin
                            // Rising edge: flash data is sampled here
                            sclk_q <= 1'b1;
                            if (state_q == S_DATA && cnt_q < CNT_W'(FRAME_BITS)) begin
                                pix_we_q   <= 1'b1;
                                pix_data_q <= MISO;
                            end
                        end else begin
                            // Falling edge: bit complete, present the next MOSI bit
                            sclk_q <= 1'b0;
                            cnt_q  <= cnt_q + CNT_W'(1);
                            mosi_q <= tx_q[30];
                            tx_q   <= {tx_q[29:0], 1'b0};
                            if (state_q == S_CMD) begin
                                if (cnt_q == CNT_W'(7)) begin
                                    state_q <= S_ADDR;
                                end
                            end else if (state_q == S_ADDR) begin
                                if (cnt_q == CNT_W'(31)) begin
                                    state_q <= S_DATA;
                                    cnt_q   <= '0;
                                    mosi_q  <= 1'b0;
                                end
                            end else begin
                                mosi_q <= 1'b0;
                                if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                                    state_q       <= S_WAIT_SWAP;
                                    cs_n_q        <= 1'b1;
                                    x_q           <= '0;
                                    y_q           <= '0;
                                    frame_ready_q <= 1'b1;
                                    cnt_q         <= '0;
                                end
                            end
                        end
                    end
                end

                S_WAIT_SWAP: begin
                    if (bank_swap) begin
                        frame_ready_q <= 1'b0;
                        if (index_wrap_d && !LOOP) begin
                            // Index stays on the last frame, which remains displayed
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q       <= S_CMD;
                            frame_index_q <= index_d;
                            cs_n_q        <= 1'b0;
                            sclk_q        <= 1'b0;
                            mosi_q        <= C_CMD_READ[7];
                            tx_q          <= {C_CMD_READ[6:0], addr_d};
                            cnt_q         <= '0;
                        end
                    end
                end

                S_DONE: begin
                    done_q <= 1'b1;
                    cs_n_q <= 1'b1;
                end

                default: begin
                    state_q <= S_IDLE;
                    cs_n_q  <= 1'b1;
                    sclk_q  <= 1'b0;
                end
            endcase
        end
    end

    assign SPI_CS_n    = cs_n_q;
    assign SPI_SCLK    = sclk_q;
    assign SPI_MOSI    = mosi_q;
    assign pixel_data  = pix_data_q;
    assign pixel_we    = pix_we_q;
    assign mem_x_pos   = x_q;
    assign mem_y_pos   = y_q;
    assign frame_ready = frame_ready_q;
    assign frame_index = frame_index_q;
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spi_frame_loader
//  Purpose  : Self-checking bench for spi_frame_loader: default geometry
//             (8x6, 32 frames, no loop) and a small looping 5x3 instance.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_frame_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] start;
    logic [1:0] swap;
    logic [1:0] miso_v;

    always #12 clk = ~clk;

    // Instance A: default parameters
    logic       a_cs, a_sclk, a_mosi, a_pd, a_we, a_fr, a_done;
    logic [2:0] a_x, a_y;
    logic [4:0] a_fi;
    // Instance B: 5x3 pixels, 2 frames, looping, base 0x10
    logic       b_cs, b_sclk, b_mosi, b_pd, b_we, b_fr, b_done;
    logic [2:0] b_x;
    logic [1:0] b_y;
    logic [0:0] b_fi;

    spi_frame_loader dut_a (
        .CLK_40(clk), .reset(rst), .SPI_clk_en(en), .start(start[0]),
        .bank_swap(swap[0]), .MISO(miso_v[0]), .SPI_CS_n(a_cs), .SPI_SCLK(a_sclk),
        .SPI_MOSI(a_mosi), .pixel_data(a_pd), .pixel_we(a_we), .mem_x_pos(a_x),
        .mem_y_pos(a_y), .frame_ready(a_fr), .frame_index(a_fi), .done(a_done)
    );

    spi_frame_loader #(
        .X_WIDTH(5), .Y_HEIGHT(3), .NUM_FRAMES(2), .BASE_ADDR(24'h000010), .LOOP(1'b1)
    ) dut_b (
        .CLK_40(clk), .reset(rst), .SPI_clk_en(en), .start(start[1]),
        .bank_swap(swap[1]), .MISO(miso_v[1]), .SPI_CS_n(b_cs), .SPI_SCLK(b_sclk),
        .SPI_MOSI(b_mosi), .pixel_data(b_pd), .pixel_we(b_we), .mem_x_pos(b_x),
        .mem_y_pos(b_y), .frame_ready(b_fr), .frame_index(b_fi), .done(b_done)
    );

    logic cs [2], sclk [2], mosi [2], pd [2], we [2], fr [2], dn [2];
    int   mx [2], my [2], fi [2];
    assign cs[0] = a_cs;   assign cs[1] = b_cs;
    assign sclk[0] = a_sclk; assign sclk[1] = b_sclk;
    assign mosi[0] = a_mosi; assign mosi[1] = b_mosi;
    assign pd[0] = a_pd;   assign pd[1] = b_pd;
    assign we[0] = a_we;   assign we[1] = b_we;
    assign fr[0] = a_fr;   assign fr[1] = b_fr;
    assign dn[0] = a_done; assign dn[1] = b_done;
    assign mx[0] = 32'(a_x);  assign mx[1] = 32'(b_x);
    assign my[0] = 32'(a_y);  assign my[1] = 32'(b_y);
    assign fi[0] = 32'(a_fi); assign fi[1] = 32'(b_fi);

    localparam int XW [2] = '{8, 5};

    // Flash contents: first six bytes fixed, the rest a simple address function
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'd0:   return 8'hA5;
            24'd1:   return 8'h3C;
            24'd2:   return 8'hFF;
            24'd3:   return 8'h00;
            24'd4:   return 8'h81;
            24'd5:   return 8'h7E;
            default: return a[7:0] ^ 8'hC3;
        endcase
    endfunction

    function automatic logic exp_bit(input logic [23:0] base, input int p);
        logic [7:0] b;
        b = flash_byte(base + 24'(p >> 3));
        return b[7 - (p & 7)];
    endfunction

    // Monitor / flash-model state per instance
    int          rise_cnt [2];
    logic [31:0] hdr [2];
    int          pix_cnt [2], order_err [2], tot_pix [2];
    int          tick_cnt [2], ready_ticks [2], hi_run [2], last_hi_run [2];
    logic [63:0] wr_bits [2];
    logic        last_cs [2], last_sclk [2], last_fr [2];
    bit          counting [2];
    logic        en_last = 1'b0;

    // Flash drives the next data bit as soon as the previous one has been clocked
    always_comb begin
        logic [7:0] fb;
        int         k;
        for (int g = 0; g < 2; g++) begin
            miso_v[g] = 1'b0;
            k  = rise_cnt[g] - 32;
            fb = 8'h00;
            if (rise_cnt[g] >= 32) begin
                fb        = flash_byte(hdr[g][23:0] + 24'(k >> 3));
                miso_v[g] = fb[7 - (k & 7)];
            end
        end
    end

    // Bus monitor, sampled on the falling clock edge
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                rise_cnt[g] = 0; hdr[g] = '0; pix_cnt[g] = 0; order_err[g] = 0;
                tot_pix[g] = 0; tick_cnt[g] = 0; ready_ticks[g] = 0; hi_run[g] = 0;
                last_hi_run[g] = 0; wr_bits[g] = '0; counting[g] = 1'b0;
                last_cs[g] = 1'b1; last_sclk[g] = 1'b0; last_fr[g] = 1'b0;
            end else begin
                if (counting[g] && en_last) tick_cnt[g]++;
                if (fr[g] && !last_fr[g]) begin
                    ready_ticks[g] = tick_cnt[g];
                    counting[g]    = 1'b0;
                end
                if (!cs[g] && last_cs[g]) begin
                    last_hi_run[g] = hi_run[g];
                    rise_cnt[g] = 0; hdr[g] = '0; pix_cnt[g] = 0; order_err[g] = 0;
                    tick_cnt[g] = 0; counting[g] = 1'b1; wr_bits[g] = '0;
                end
                if (cs[g]) hi_run[g]++; else hi_run[g] = 0;
                if (!cs[g] && sclk[g] && !last_sclk[g]) begin
                    if (rise_cnt[g] < 32) hdr[g] = {hdr[g][30:0], mosi[g]};
                    rise_cnt[g]++;
                end
                if (we[g]) begin
                    if (mx[g] != pix_cnt[g] % XW[g] || my[g] != pix_cnt[g] / XW[g])
                        order_err[g]++;
                    if (pix_cnt[g] < 64) wr_bits[g][pix_cnt[g]] = pd[g];
                    pix_cnt[g]++;
                    tot_pix[g]++;
                end
                last_cs[g] = cs[g]; last_sclk[g] = sclk[g]; last_fr[g] = fr[g];
            end
        end
        en_last = en;
    end

    // SPI_clk_en strobe: one cycle in three
    initial begin
        int ecnt;
        ecnt = 0;
        en   = 1'b0;
        forever begin
            @(posedge clk); #1;
            en   = (ecnt == 0);
            ecnt = (ecnt + 1) % 3;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic smp();
        @(negedge clk); #1;
    endtask

    task automatic drive_edge();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1; drive_edge(); start[d] = 1'b0;
    endtask

    task automatic pulse_swap(input int d);
        swap[d] = 1'b1; drive_edge(); swap[d] = 1'b0;
    endtask

    task automatic wait_ready(input int d);
        int n;
        n = 0;
        while (!fr[d] && n < 3000) begin smp(); n++; end
        chk("ready_timeout", 32'(fr[d]), 32'd1);
    endtask

    task automatic wait_rises(input int d, input int r);
        int n;
        n = 0;
        while (rise_cnt[d] < r && n < 2000) begin smp(); n++; end
        chk("rise_timeout", 32'(rise_cnt[d] >= r), 32'd1);
    endtask

    typedef struct {
        int          d;        // instance
        int          ign;      // 1: swap mid-DATA, 2: start mid-DATA
        int          fidx;
        logic [31:0] hdr;
        int          npix;
        int          ticks;
        logic [7:0]  first8;
        logic        lastpix;
    } vec_t;

    vec_t tv [6];

    initial begin
        logic [7:0] f8;
        int         mism, snap, d;

        tv[0] = '{0, 0, 0, 32'h03000000, 48, 160, 8'hA5, 1'b0};
        tv[1] = '{0, 1, 1, 32'h03000006, 48, 160, 8'hC5, 1'b0};
        tv[2] = '{0, 2, 2, 32'h0300000C, 48, 160, 8'hCF, 1'b0};
        tv[3] = '{1, 0, 0, 32'h03000010, 15,  96, 8'hD3, 1'b1};
        tv[4] = '{1, 0, 1, 32'h03000012, 15,  96, 8'hD1, 1'b0};
        tv[5] = '{1, 1, 0, 32'h03000010, 15,  96, 8'hD3, 1'b1};

        rst = 1'b1; start = '0; swap = '0;
        repeat (3) drive_edge();
        smp();
        for (int g = 0; g < 2; g++) begin
            chk("rst_cs_n", 32'(cs[g]), 32'd1);
            chk("rst_sclk", 32'(sclk[g]), 32'd0);
            chk("rst_mosi", 32'(mosi[g]), 32'd0);
            chk("rst_we", 32'(we[g]), 32'd0);
            chk("rst_pdata", 32'(pd[g]), 32'd0);
            chk("rst_x", 32'(mx[g]), 32'd0);
            chk("rst_y", 32'(my[g]), 32'd0);
            chk("rst_ready", 32'(fr[g]), 32'd0);
            chk("rst_index", 32'(fi[g]), 32'd0);
            chk("rst_done", 32'(dn[g]), 32'd0);
        end
        drive_edge();
        rst = 1'b0;
        repeat (4) drive_edge();

        for (int v = 0; v < 6; v++) begin
            d = tv[v].d;
            if (v == 0 || v == 3) pulse_start(d); else pulse_swap(d);
            if (tv[v].ign != 0) begin
                wait_rises(d, 40);
                if (tv[v].ign == 1) pulse_swap(d); else pulse_start(d);
            end
            wait_ready(d);
            chk("header", hdr[d], tv[v].hdr);
            chk("pix_count", 32'(pix_cnt[d]), 32'(tv[v].npix));
            chk("ready_ticks", 32'(ready_ticks[d]), 32'(tv[v].ticks));
            chk("sclk_rises", 32'(rise_cnt[d]), 32'(tv[v].ticks / 2));
            for (int i = 0; i < 8; i++) f8[7 - i] = wr_bits[d][i];
            chk("first8", 32'(f8), 32'(tv[v].first8));
            chk("last_pix", 32'(wr_bits[d][tv[v].npix - 1]), 32'(tv[v].lastpix));
            mism = 0;
            for (int p = 0; p < tv[v].npix; p++)
                if (wr_bits[d][p] !== exp_bit(tv[v].hdr[23:0], p)) mism++;
            chk("frame_data", 32'(mism), 32'd0);
            chk("addr_order", 32'(order_err[d]), 32'd0);
            chk("frame_index", 32'(fi[d]), 32'(tv[v].fidx));
            chk("cs_after_frame", 32'(cs[d]), 32'd1);
            chk("xy_after_frame", 32'(mx[d] + my[d]), 32'd0);
            if (v != 0 && v != 3) chk("cs_gap", 32'(last_hi_run[d] >= 1), 32'd1);
            repeat (30) smp();
            chk("hold_ready", 32'(fr[d]), 32'd1);
            chk("hold_no_pix", 32'(pix_cnt[d]), 32'(tv[v].npix));
        end

        // Run instance A through the rest of the clip
        for (int f = 3; f < 32; f++) begin
            pulse_swap(0);
            wait_ready(0);
            chk("seq_index", 32'(fi[0]), 32'(f));
            chk("seq_pix_count", 32'(pix_cnt[0]), 32'd48);
        end
        pulse_swap(0);
        repeat (5) smp();
        chk("done", 32'(dn[0]), 32'd1);
        chk("done_cs", 32'(cs[0]), 32'd1);
        chk("done_ready", 32'(fr[0]), 32'd0);
        snap = tot_pix[0];
        pulse_start(0);
        pulse_swap(0);
        repeat (400) smp();
        chk("done_no_pix", 32'(tot_pix[0]), 32'(snap));
        chk("done_hold", 32'(dn[0]), 32'd1);
        chk("done_cs_hold", 32'(cs[0]), 32'd1);

        // Reset out of DONE, then abort a transfer in the middle of ADDR
        rst = 1'b1; drive_edge(); rst = 1'b0;
        drive_edge();
        chk("reset_clears_done", 32'(dn[0]), 32'd0);
        pulse_start(0);
        wait_rises(0, 12);
        rst = 1'b1; drive_edge();
        smp();
        chk("abort_cs_n", 32'(cs[0]), 32'd1);
        chk("abort_sclk", 32'(sclk[0]), 32'd0);
        chk("abort_mosi", 32'(mosi[0]), 32'd0);
        chk("abort_index", 32'(fi[0]), 32'd0);
        rst = 1'b0;
        repeat (3) drive_edge();
        pulse_start(0);
        wait_ready(0);
        chk("restart_header", hdr[0], 32'h03000000);
        chk("restart_index", 32'(fi[0]), 32'd0);
        chk("restart_pix_count", 32'(pix_cnt[0]), 32'd48);
        for (int i = 0; i < 8; i++) f8[7 - i] = wr_bits[0][i];
        chk("restart_first8", 32'(f8), 32'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
